// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_target_regs_pkg;

    // Protocol FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_ACK     = 3'd2,
        ST_WR_PTR  = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_RD_ACK  = 3'd6,
        ST_IGNORE  = 3'd7
    } state_t;

    // Value of the R/W bit in the address byte.
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer plus run-length glitch filter for one I2C line.
// The filtered level only follows the synchronized input after FILTER_LEN
// consecutive samples disagree with it; rise/fall pulses are registered
// together with the level so they are always consistent with it.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count how long the synchronized line has disagreed with the filtered level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
                fall_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer and filter state; idle bus is high, so reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-addressed register file with EEPROM-style
// pointer addressing: the first byte after a write address loads the
// pointer, later bytes read or write with auto-increment.
module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         ADDR_WIDTH = 8,
    parameter int         FILTER_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    output logic                  scl_o,
    output logic                  scl_t,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_t,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [7:0]            reg_wr_data,
    input  logic [7:0]            reg_rd_data,
    output logic                  busy,
    output logic                  bus_active
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (scl_i),
        .level_o (scl_f),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (sda_i),
        .level_o (sda_f),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic                  ptr_done_q, ptr_done_d;
    logic                  sda_q, sda_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  bus_active_q, bus_active_d;

    logic       start_cond;
    logic       stop_cond;
    logic [7:0] byte_in;

    assign start_cond = sda_fall & scl_f;
    assign stop_cond  = sda_rise & scl_f;
    // Byte as it stands once the bit on the current scl_rise is shifted in.
    assign byte_in    = {shift_q[6:0], sda_f};

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        ptr_done_d   = ptr_done_q;
        sda_d        = sda_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        bus_active_d = bus_active_q;
        // The pointer advances the cycle after a write strobe.
        addr_d       = wr_en_q ? addr_q + ADDR_WIDTH'(1) : addr_q;

        if (start_cond) begin
            state_d      = ST_ADDR;
            bit_cnt_d    = 4'd0;
            sda_d        = 1'b1;
            ptr_done_d   = 1'b0;
            bus_active_d = 1'b1;
        end else if (stop_cond) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = 4'd0;
            sda_d        = 1'b1;
            busy_d       = 1'b0;
            bus_active_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_IGNORE: begin
                    sda_d = 1'b1;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = ST_ACK;
                                busy_d  = 1'b1;
                                rw_d    = byte_in[0] ? RW_READ : RW_WRITE;
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_ACK: begin
                    // bit_cnt 0: waiting for the fall after bit 8; 1: ACK is on the bus.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_d     = 1'b0;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_d     = 1'b1;
                            bit_cnt_d = 4'd0;
                            if (rw_q == RW_WRITE) begin
                                state_d = ptr_done_q ? ST_WR_DATA : ST_WR_PTR;
                            end else begin
                                // First read bit must go out on this very fall.
                                state_d   = ST_RD_DATA;
                                shift_d   = {reg_rd_data[6:0], 1'b1};
                                sda_d     = reg_rd_data[7];
                                addr_d    = addr_q + ADDR_WIDTH'(1);
                                bit_cnt_d = 4'd1;
                            end
                        end
                    end
                end
                ST_WR_PTR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (bit_cnt_q == 4'd7) begin
                            addr_d     = ADDR_WIDTH'(byte_in);
                            ptr_done_d = 1'b1;
                            state_d    = ST_ACK;
                            bit_cnt_d  = 4'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (bit_cnt_q == 4'd7) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = byte_in;
                            state_d   = ST_ACK;
                            bit_cnt_d = 4'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // bit_cnt counts bits already placed on SDA for this byte.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            shift_d   = {reg_rd_data[6:0], 1'b1};
                            sda_d     = reg_rd_data[7];
                            addr_d    = addr_q + ADDR_WIDTH'(1);
                            bit_cnt_d = 4'd1;
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_d     = 1'b1;
                            state_d   = ST_RD_ACK;
                            bit_cnt_d = 4'd0;
                        end else begin
                            sda_d     = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd0;
                        state_d   = sda_f ? ST_IGNORE : ST_RD_DATA;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sda_d   = 1'b1;
                end
            endcase
        end
    end

    // State registers; reset releases SDA and forgets any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            rw_q         <= RW_WRITE;
            ptr_done_q   <= 1'b0;
            sda_q        <= 1'b1;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 8'd0;
            busy_q       <= 1'b0;
            bus_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            ptr_done_q   <= ptr_done_d;
            sda_q        <= sda_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            bus_active_q <= bus_active_d;
        end
    end

    assign scl_o       = 1'b1;
    assign scl_t       = 1'b1;
    assign sda_o       = sda_q;
    assign sda_t       = sda_q;
    assign reg_addr    = addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign bus_active  = bus_active_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: a bit-banged I2C controller drives the open-drain bus,
// a scoreboard queue holds expected register writes, and a monitor pops
// and checks them whenever the target strobes reg_wr_en.
`timescale 1ns/1ps
module tb_i2c_target_regs;
    import i2c_target_regs_pkg::*;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_ctl = 1'b1;
    logic       sda_ctl = 1'b1;
    logic       glitch_en = 1'b0;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic [7:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       busy, bus_active;
    logic       scl_bus, sda_bus;

    logic [7:0] mem [256];
    wr_t        exp_q [$];
    int         total = 0;
    int         bad = 0;

    // Wired-AND open-drain bus: a pad pulls low only when enabled and driving 0.
    assign scl_bus = scl_ctl & (scl_t | scl_o);
    assign sda_bus = sda_ctl & (sda_t | sda_o);
    assign reg_rd_data = mem[reg_addr];

    always #5 clk = ~clk;

    i2c_target_regs #(
        .DEV_ADDR   (7'h50),
        .ADDR_WIDTH (8),
        .FILTER_LEN (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_bus),
        .scl_o       (scl_o),
        .scl_t       (scl_t),
        .sda_i       (sda_bus),
        .sda_o       (sda_o),
        .sda_t       (sda_t),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .bus_active  (bus_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1; wait_clk(Q);
        scl_ctl = 1'b1; wait_clk(Q);
        sda_ctl = 1'b0; wait_clk(Q);
        scl_ctl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; wait_clk(Q);
        scl_ctl = 1'b1; wait_clk(Q);
        sda_ctl = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_ctl = b;
        wait_clk(Q / 2);
        if (glitch_en) begin
            scl_ctl = 1'b1; wait_clk(1); scl_ctl = 1'b0;
        end
        wait_clk(Q / 2);
        scl_ctl = 1'b1; wait_clk(Q);
        if (glitch_en) begin
            scl_ctl = 1'b0; wait_clk(1); scl_ctl = 1'b1;
        end
        wait_clk(Q);
        scl_ctl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_ctl = 1'b1; wait_clk(Q);
        scl_ctl = 1'b1; wait_clk(Q);
        b = sda_bus;    wait_clk(Q);
        scl_ctl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
        $display("byte out 0x%02h ack=%0b", d, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
        $display("byte in  0x%02h ack=%0b", d, ack_bit);
    endtask

    task automatic monitor_loop();
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && reg_wr_en) begin
                $display("reg write addr=0x%02h data=0x%02h", reg_addr, reg_wr_data);
                mem[reg_addr] = reg_wr_data;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write",
                             reg_addr, reg_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(reg_addr), 32'(e.addr));
                    chk("wr_data", 32'(reg_wr_data), 32'(e.data));
                end
            end
        end
    endtask

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] a0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        fork
            monitor_loop();
        join_none

        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_sda_o", 32'(sda_o), 32'd1);
        chk("rst_sda_t", 32'(sda_t), 32'd1);
        chk("rst_scl_o", 32'(scl_o), 32'd1);
        chk("rst_scl_t", 32'(scl_t), 32'd1);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_active", 32'(bus_active), 32'd0);

        // Pointer write followed by two data bytes.
        i2c_start();
        chk("t1_bus_active", 32'(bus_active), 32'd1);
        write_byte(8'hA0, ack); chk("t1_addr_ack", 32'(ack), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        write_byte(8'h10, ack); chk("t1_ptr_ack", 32'(ack), 32'd0);
        push_wr(8'h10, 8'hAA);
        write_byte(8'hAA, ack); chk("t1_d0_ack", 32'(ack), 32'd0);
        push_wr(8'h11, 8'hBB);
        write_byte(8'hBB, ack); chk("t1_d1_ack", 32'(ack), 32'd0);
        i2c_stop();
        wait_clk(10);
        chk("t1_reg_addr", 32'(reg_addr), 32'h12);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_bus_idle", 32'(bus_active), 32'd0);

        // Pointer set, repeated START, read two bytes (ACK then NACK).
        i2c_start();
        write_byte(8'hA0, ack); chk("t2_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h10, ack); chk("t2_ptr_ack", 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'hA1, ack); chk("t2_raddr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, rd); chk("t2_rd0", 32'(rd), 32'hAA);
        read_byte(1'b1, rd); chk("t2_rd1", 32'(rd), 32'hBB);
        chk("t2_sda_released", 32'(sda_o), 32'd1);
        i2c_stop();
        wait_clk(10);
        chk("t2_reg_addr", 32'(reg_addr), 32'h12);
        chk("t2_busy_after", 32'(busy), 32'd0);

        // Wrong device address: no ACK, no writes, never busy.
        i2c_start();
        write_byte(8'hA2, ack); chk("t3_addr_nack", 32'(ack), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        write_byte(8'h33, ack); chk("t3_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        wait_clk(10);
        chk("t3_busy_after", 32'(busy), 32'd0);

        // Pointer wraps from 0xFF to 0x00.
        i2c_start();
        write_byte(8'hA0, ack); chk("t4_addr_ack", 32'(ack), 32'd0);
        write_byte(8'hFF, ack); chk("t4_ptr_ack", 32'(ack), 32'd0);
        push_wr(8'hFF, 8'h01);
        write_byte(8'h01, ack); chk("t4_d0_ack", 32'(ack), 32'd0);
        push_wr(8'h00, 8'h02);
        write_byte(8'h02, ack); chk("t4_d1_ack", 32'(ack), 32'd0);
        i2c_stop();
        wait_clk(10);
        chk("t4_reg_addr", 32'(reg_addr), 32'h01);

        // STOP after four data bits aborts the byte; next transfer still works.
        i2c_start();
        write_byte(8'hA0, ack); chk("t5_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h20, ack); chk("t5_ptr_ack", 32'(ack), 32'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wait_clk(10);
        chk("t5_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_reg_addr", 32'(reg_addr), 32'h20);
        i2c_start();
        write_byte(8'hA0, ack); chk("t5b_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h21, ack); chk("t5b_ptr_ack", 32'(ack), 32'd0);
        push_wr(8'h21, 8'h5A);
        write_byte(8'h5A, ack); chk("t5b_d0_ack", 32'(ack), 32'd0);
        i2c_stop();
        wait_clk(10);
        chk("t5b_reg_addr", 32'(reg_addr), 32'h22);

        // Single-clock SCL glitches during a write are filtered out.
        glitch_en = 1'b1;
        i2c_start();
        write_byte(8'hA0, ack); chk("t7_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h30, ack); chk("t7_ptr_ack", 32'(ack), 32'd0);
        push_wr(8'h30, 8'h3C);
        write_byte(8'h3C, ack); chk("t7_d0_ack", 32'(ack), 32'd0);
        push_wr(8'h31, 8'hC3);
        write_byte(8'hC3, ack); chk("t7_d1_ack", 32'(ack), 32'd0);
        i2c_stop();
        glitch_en = 1'b0;
        wait_clk(10);
        chk("t7_reg_addr", 32'(reg_addr), 32'h32);

        // Reset while the target holds ACK low.
        i2c_start();
        a0 = 8'hA0;
        for (int i = 7; i >= 0; i--) write_bit(a0[i]);
        chk("t6_ack_driven", 32'(sda_o), 32'd0);
        chk("t6_busy_before", 32'(busy), 32'd1);
        sda_ctl = 1'b1;
        rst = 1'b1;
        wait_clk(1);
        chk("t6_sda_o", 32'(sda_o), 32'd1);
        chk("t6_sda_t", 32'(sda_t), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_reg_addr", 32'(reg_addr), 32'd0);
        chk("t6_bus_active", 32'(bus_active), 32'd0);
        rst = 1'b0;
        wait_clk(Q);
        read_bit(ack); chk("t6_no_ack_after_rst", 32'(ack), 32'd1);
        i2c_stop();
        wait_clk(10);
        i2c_start();
        write_byte(8'hA0, ack); chk("t6b_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h40, ack); chk("t6b_ptr_ack", 32'(ack), 32'd0);
        push_wr(8'h40, 8'h77);
        write_byte(8'h77, ack); chk("t6b_d0_ack", 32'(ack), 32'd0);
        i2c_stop();
        wait_clk(20);
        chk("t6b_reg_addr", 32'(reg_addr), 32'h41);

        chk("no_pending_writes", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
